// File: rtl/mdr_pkg.sv
// mdr_pkg: encodings shared by the multiply/divide/root sequencer and its
// counter. The error result is kept wide so any operand width can slice it.
package mdr_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int unsigned RESULT_MAX_W = 64;
    localparam logic [RESULT_MAX_W-1:0] ERR_RESULT = '1;

endpackage

// File: rtl/mdr_counter.sv
// mdr_counter: iteration counter for the sequencer. Cleared when the
// operands are loaded, advanced once per RUN cycle; ov_count flags the
// final iteration (count == N-1).
module mdr_counter
    import mdr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic ov_count
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count;

    // Iteration count: clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    // Last-iteration flag straight from the register.
    always_comb begin
        ov_count = (count == CW'(N - 1));
    end

endmodule

// File: rtl/mdr_sequencer.sv
// mdr_sequencer: control and register file for an iterative multiply
// (Booth), divide (non-restoring) and square-root engine. The per-step
// arithmetic lives outside; this block owns A:Q, M, the counter and the
// result/flag handshake.
// Build option: define MDR_SQRT_EN to make op=10 a legal square root and
// keep the root M update; otherwise op=10 is rejected as illegal.
//
// state  | meaning
// S_IDLE | waiting for start, ready high, result/error held
// S_LOAD | operands copied into A:Q and M, counter cleared
// S_RUN  | one step per cycle, aq_reg <= aq_next, N cycles total
// S_DONE | one-cycle done pulse, result already written
module mdr_sequencer
    import mdr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   data_a,
    input  logic [N-1:0]   data_b,
    input  logic [2*N:0]   aq_next,
    output logic [N-1:0]   a,
    output logic [N-1:0]   a_plus_m,
    output logic [N-1:0]   a_minus_m,
    output logic [N:0]     q,
    output logic [2*N:0]   aq_reg,
    output logic           msb_AM,
    output logic           msb_reg_A,
    output logic           ov_count,
    output logic [1:0]     op_q,
    output logic [2*N-1:0] result,
    output logic           ready,
    output logic           done,
    output logic           error
);

    state_e         state;
    state_e         state_nxt;
    op_e            op_in;
    logic           op_legal;
    logic           start_fault;
    logic           load_fault;
    logic [N-1:0]   m_reg;
    logic [N-1:0]   opa_reg;
    logic [N-1:0]   opb_reg;
    logic [N-1:0]   a_fin;
    logic [N-1:0]   rem_fin;
    logic [2*N-1:0] final_result;

    assign op_in = op_e'(op);

`ifdef MDR_SQRT_EN
    assign op_legal = (op_in != OP_ILL);
`else
    assign op_legal = (op_in == OP_MUL) || (op_in == OP_DIV);
`endif

    // A zero divisor is caught when start is sampled so every fault reports
    // one cycle later; the LOAD check stays as a guard on the latched value.
    assign start_fault = !op_legal || ((op_in == OP_DIV) && (data_b == '0));
    assign load_fault  = (op_e'(op_q) == OP_DIV) && (opb_reg == '0);

    assign a         = aq_reg[2*N:N+1];
    assign q         = aq_reg[N:0];
    assign a_plus_m  = a + m_reg;
    assign a_minus_m = a - m_reg;
    assign msb_AM    = a[N-1];
    assign msb_reg_A = aq_reg[2*N];

    mdr_counter #(.N(N)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_LOAD),
        .inc      (state == S_RUN),
        .ov_count (ov_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = start_fault ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = load_fault ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (ov_count) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, A:Q load/step and M register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            opa_reg <= '0;
            opb_reg <= '0;
            aq_reg  <= '0;
            m_reg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        opa_reg <= data_a;
                        opb_reg <= data_b;
                    end
                end
                S_LOAD: begin
                    aq_reg <= {{N{1'b0}}, opa_reg, 1'b0};
                    m_reg  <= (op_e'(op_q) == OP_SQRT) ? '0 : opb_reg;
                end
                S_RUN: begin
                    aq_reg <= aq_next;
`ifdef MDR_SQRT_EN
                    if (op_e'(op_q) == OP_SQRT) begin
                        m_reg <= {q[N-2:1], 2'b01};
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Result formed from the final step value so it is valid with done.
    always_comb begin
        a_fin   = aq_next[2*N:N+1];
        rem_fin = a_fin[N-1] ? (a_fin + m_reg) : a_fin;
        case (op_e'(op_q))
            OP_MUL:  final_result = aq_next[2*N:1];
            OP_DIV:  final_result = {rem_fin, aq_next[N:1]};
`ifdef MDR_SQRT_EN
            OP_SQRT: final_result = {{N{1'b0}}, aq_next[N:1]};
`endif
            default: final_result = ERR_RESULT[2*N-1:0];
        endcase
    end

    // Result and error: cleared error on an accepted start, set on faults,
    // result written on entry to DONE and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error <= start_fault;
                        if (start_fault) begin
                            result <= ERR_RESULT[2*N-1:0];
                        end
                    end
                end
                S_LOAD: begin
                    if (load_fault) begin
                        error  <= 1'b1;
                        result <= ERR_RESULT[2*N-1:0];
                    end
                end
                S_RUN: begin
                    if (ov_count) begin
                        result <= final_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_sequencer.sv
// tb_mdr_sequencer: directed bench for mdr_sequencer with N=4 and a
// behavioural step datapath closing the aq_next loop.
module tb_mdr_sequencer;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   data_a;
    logic [N-1:0]   data_b;
    logic [2*N:0]   aq_next;
    logic [N-1:0]   a;
    logic [N-1:0]   a_plus_m;
    logic [N-1:0]   a_minus_m;
    logic [N:0]     q;
    logic [2*N:0]   aq_reg;
    logic           msb_AM;
    logic           msb_reg_A;
    logic           ov_count;
    logic [1:0]     op_q;
    logic [2*N-1:0] result;
    logic           ready;
    logic           done;
    logic           error;

    int passed = 0;
    int total  = 0;

    mdr_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .data_a    (data_a),
        .data_b    (data_b),
        .aq_next   (aq_next),
        .a         (a),
        .a_plus_m  (a_plus_m),
        .a_minus_m (a_minus_m),
        .q         (q),
        .aq_reg    (aq_reg),
        .msb_AM    (msb_AM),
        .msb_reg_A (msb_reg_A),
        .ov_count  (ov_count),
        .op_q      (op_q),
        .result    (result),
        .ready     (ready),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step datapath: Booth multiply, non-restoring divide, counting root.
    logic [N-1:0] s_a;
    logic [N-1:0] s_m;
    logic [N-1:0] s_sh;
    logic [N-1:0] s_na;
    logic [N:0]   s_q;
    int           s_cand;

    always_comb begin
        s_a     = aq_reg[2*N:N+1];
        s_q     = aq_reg[N:0];
        s_m     = a_plus_m - s_a;
        s_sh    = {s_a[N-2:0], s_q[N]};
        s_na    = s_a;
        s_cand  = int'(s_a) + 1;
        aq_next = aq_reg;
        case (op_q)
            2'b00: begin
                if (s_q[1:0] == 2'b01) s_na = a_plus_m;
                else if (s_q[1:0] == 2'b10) s_na = a_minus_m;
                aq_next = {s_na[N-1], s_na, s_q[N:1]};
            end
            2'b01: begin
                s_na    = s_a[N-1] ? (s_sh + s_m) : (s_sh - s_m);
                aq_next = {s_na, s_q[N-1:1], ~s_na[N-1], 1'b0};
            end
            2'b10: begin
                if (s_cand * s_cand <= int'(s_q[N:1])) s_na = s_a + 1'b1;
                aq_next = ov_count ? {s_na, s_na, 1'b0} : {s_na, s_q};
            end
            default: aq_next = aq_reg;
        endcase
    end

    // Runs one operation from a negedge; lat is the number of rising edges
    // from the start-sampling edge to the edge that samples done high.
    task automatic do_op(input logic [1:0] o, input logic [N-1:0] da,
                         input logic [N-1:0] db, output int lat,
                         output logic [2*N-1:0] res, output logic err,
                         output int ov_idx, output logic pulse_ok,
                         output logic err_early);
        logic got;
        got       = 1'b0;
        lat       = -1;
        ov_idx    = -1;
        res       = '0;
        err       = 1'b0;
        pulse_ok  = 1'b0;
        err_early = 1'b0;
        op        = o;
        data_a    = da;
        data_b    = db;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == 1) err_early = error;
            if (ov_count && ov_idx < 0) ov_idx = i;
            if (done) begin
                got = 1'b1;
                lat = i;
                res = result;
                err = error;
            end
        end
        @(negedge clk);
        pulse_ok = !done && ready;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        data_a = '0;
        data_b = '0;
        #12;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (result !== 8'h00) $display("FAIL reset_result: got %h expected 00", result); else passed++;
        total++; if (aq_reg !== 9'h000) $display("FAIL reset_aq: got %h expected 000", aq_reg); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        int lat, ovi; logic [2*N-1:0] res; logic err, pok, ee;
        do_op(2'b00, 4'd3, 4'hE, lat, res, err, ovi, pok, ee);
        total++; if (res !== 8'hFA) $display("FAIL mul_3x-2_result: got %h expected fa", res); else passed++;
        total++; if (lat !== 6) $display("FAIL mul_latency: got %0d expected 6", lat); else passed++;
        total++; if (ovi !== 5) $display("FAIL mul_ov_count_cycle: got %0d expected 5", ovi); else passed++;
        total++; if (pok !== 1'b1) $display("FAIL mul_done_one_cycle: got %b expected 1", pok); else passed++;
        total++; if (err !== 1'b0) $display("FAIL mul_error: got %b expected 0", err); else passed++;
    endtask

    task automatic test_divide();
        int lat, ovi; logic [2*N-1:0] res; logic err, pok, ee;
        do_op(2'b01, 4'd7, 4'd2, lat, res, err, ovi, pok, ee);
        total++; if (res !== 8'h13) $display("FAIL div_7_2_result: got %h expected 13", res); else passed++;
        total++; if (err !== 1'b0) $display("FAIL div_7_2_error: got %b expected 0", err); else passed++;
        total++; if (lat !== 6) $display("FAIL div_latency: got %0d expected 6", lat); else passed++;
    endtask

    task automatic test_div_zero();
        int lat, ovi; logic [2*N-1:0] res; logic err, pok, ee;
        do_op(2'b01, 4'd5, 4'd0, lat, res, err, ovi, pok, ee);
        total++; if (lat !== 1) $display("FAIL div0_latency: got %0d expected 1", lat); else passed++;
        total++; if (err !== 1'b1) $display("FAIL div0_error: got %b expected 1", err); else passed++;
        total++; if (res !== 8'hFF) $display("FAIL div0_result: got %h expected ff", res); else passed++;
        total++; if (ovi !== -1) $display("FAIL div0_no_run: got %0d expected -1", ovi); else passed++;
        repeat (3) @(negedge clk);
        total++; if (result !== 8'hFF || error !== 1'b1)
            $display("FAIL div0_hold: got %h/%b expected ff/1", result, error); else passed++;
        // Negative final remainder needs the A+M correction; error clears on accept.
        do_op(2'b01, 4'd2, 4'd3, lat, res, err, ovi, pok, ee);
        total++; if (ee !== 1'b0) $display("FAIL div_error_clear: got %b expected 0", ee); else passed++;
        total++; if (res !== 8'h20) $display("FAIL div_2_3_result: got %h expected 20", res); else passed++;
    endtask

    task automatic test_illegal();
        int lat, ovi; logic [2*N-1:0] res; logic err, pok, ee;
        do_op(2'b11, 4'd1, 4'd1, lat, res, err, ovi, pok, ee);
        total++; if (lat !== 1 || err !== 1'b1 || res !== 8'hFF)
            $display("FAIL illegal_op: got lat=%0d err=%b res=%h expected 1/1/ff", lat, err, res); else passed++;
    endtask

    task automatic test_sqrt();
        int lat, ovi; logic [2*N-1:0] res; logic err, pok, ee;
        do_op(2'b10, 4'd9, 4'd0, lat, res, err, ovi, pok, ee);
`ifdef MDR_SQRT_EN
        total++; if (res !== 8'h03) $display("FAIL sqrt_9_result: got %h expected 03", res); else passed++;
        total++; if (err !== 1'b0 || lat !== 6) $display("FAIL sqrt_9_flags: got err=%b lat=%0d expected 0/6", err, lat); else passed++;
`else
        total++; if (res !== 8'hFF) $display("FAIL sqrt_off_result: got %h expected ff", res); else passed++;
        total++; if (err !== 1'b1 || lat !== 1) $display("FAIL sqrt_off_flags: got err=%b lat=%0d expected 1/1", err, lat); else passed++;
`endif
    endtask

    task automatic test_reset_mid_run();
        int lat, ovi, hits; logic [2*N-1:0] res; logic err, pok, ee;
        op     = 2'b00;
        data_a = 4'd5;
        data_b = 4'd3;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) hits++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL rst_run_ready: got %b expected 1", ready); else passed++;
        total++; if ({aq_reg, a_plus_m, a_minus_m, op_q, result} !== '0)
            $display("FAIL rst_run_datapath: got aq=%h ap=%h am=%h op=%b res=%h expected all 0",
                     aq_reg, a_plus_m, a_minus_m, op_q, result); else passed++;
        total++; if ({done, error, ov_count, msb_AM, msb_reg_A} !== 5'b0)
            $display("FAIL rst_run_flags: got %b expected 00000",
                     {done, error, ov_count, msb_AM, msb_reg_A}); else passed++;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) hits++;
        end
        total++; if (hits !== 0) $display("FAIL rst_run_no_done: got %0d expected 0", hits); else passed++;
        do_op(2'b00, 4'd2, 4'd2, lat, res, err, ovi, pok, ee);
        total++; if (res !== 8'h04) $display("FAIL mul_2x2_result: got %h expected 04", res); else passed++;
        total++; if (lat !== 6) $display("FAIL mul_2x2_latency: got %0d expected 6", lat); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2*N-1:0] res;
        logic op_ok;
        op     = 2'b01;
        data_a = 4'd7;
        data_b = 4'd2;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat   = -1;
        res   = '0;
        op_ok = 1'b1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 2) begin
                op     = 2'b00;
                data_a = 4'd3;
                data_b = 4'd3;
                start  = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (i >= 2 && i <= 5 && op_q !== 2'b01) op_ok = 1'b0;
            if (done) begin
                lat = i;
                res = result;
            end
        end
        start = 1'b0;
        total++; if (res !== 8'h13) $display("FAIL b2b_result: got %h expected 13", res); else passed++;
        total++; if (lat !== 6) $display("FAIL b2b_latency: got %0d expected 6", lat); else passed++;
        total++; if (op_ok !== 1'b1) $display("FAIL b2b_op_held: got %b expected 1", op_ok); else passed++;
        repeat (3) @(negedge clk);
        total++; if (result !== 8'h13 || ready !== 1'b1)
            $display("FAIL b2b_hold: got %h/%b expected 13/1", result, ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_illegal();
        test_sqrt();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
